// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter: register
// addressing constants, the write-source tag and a one-hot helper.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_LU   = 1'b1
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return one << addr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of long-latency writeback requests. Exposes a per-entry
// valid/addr view so the owner can build a register-pending mask.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int width = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [REG_ADDR_W-1:0]         push_addr_i,
  input  logic [width-1:0]              push_data_i,
  input  logic                          pop_i,
  output logic [REG_ADDR_W-1:0]         head_addr_o,
  output logic [width-1:0]              head_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH-1:0]              entry_valid_o,
  output logic [DEPTH*REG_ADDR_W-1:0]   entry_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [width-1:0]      data;
  } wb_req_t;

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_addr_o = mem_q[rd_ptr_q].addr;
  assign head_data_o = mem_q[rd_ptr_q].data;

  // Pointers are PTR_W bits wide, so the increment wraps modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observed while
  // its valid bit (derived from the reset pointers) is set.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset = PTR_W'(i) - rd_ptr_q;
    assign entry_valid_o[i] = ({1'b0, offset} < count_q);
    assign entry_addr_o[i*REG_ADDR_W +: REG_ADDR_W] = mem_q[i].addr;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single driver of the register-file write port: the pipeline writeback has
// fixed priority, long-latency results drain from a FIFO when the port is idle.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int width        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_wr_enable,
  input  logic [REG_ADDR_W-1:0] pipe_W_addr,
  input  logic [width-1:0]      pipe_W_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [width-1:0]      lu_data,
  output logic                  lu_ready,
  output logic [REG_ADDR_W-1:0] W_addr,
  output logic [width-1:0]      W_data,
  output logic                  wr_enable,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic                  stall_req
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                          fifo_full, fifo_empty;
  logic [REG_ADDR_W-1:0]         head_addr;
  logic [width-1:0]              head_data;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH*REG_ADDR_W-1:0]   entry_addr;
  logic                          pipe_eff, lu_push, lu_pop;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [width-1:0]      w_data_q, w_data_d;
  wb_src_t               src_q, src_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  stall_q;

  // Writes to r0 are architectural no-ops, so they never claim the port.
  assign pipe_eff = pipe_wr_enable && (pipe_W_addr != ZERO_REG);
  assign lu_pop   = !pipe_eff && !fifo_empty;
  assign lu_ready = !fifo_full;
  assign lu_push  = lu_valid && lu_ready && (lu_addr != ZERO_REG);

  wb_fifo #(
    .width (width),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (lu_push),
    .push_addr_i   (lu_addr),
    .push_data_i   (lu_data),
    .pop_i         (lu_pop),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_addr_o  (entry_addr)
  );

  // NOTE: every output of a combinational block gets a default up front, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    wr_en_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    src_d    = src_q;
    if (pipe_eff) begin
      wr_en_d  = 1'b1;
      w_addr_d = pipe_W_addr;
      w_data_d = pipe_W_data;
      src_d    = WB_SRC_PIPE;
    end else if (!fifo_empty) begin
      wr_en_d  = 1'b1;
      w_addr_d = head_addr;
      w_data_d = head_data;
      src_d    = WB_SRC_LU;
    end

    starve_d = '0;
    if (!fifo_empty && pipe_eff) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      src_q    <= WB_SRC_PIPE;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_en_q  <= wr_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      src_q    <= src_d;
      starve_q <= starve_d;
      stall_q  <= (starve_d == STARVE_MAX);
    end
  end

  assign wr_enable = wr_en_q;
  assign W_addr    = w_addr_q;
  assign W_data    = w_data_q;
  assign stall_req = stall_q;

  // A result is pending from enqueue until it has left the output stage.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        pending_mask |= reg_onehot(entry_addr[i*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
    if (wr_en_q && (src_q == WB_SRC_LU)) begin
      pending_mask |= reg_onehot(w_addr_q);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based reference model is
// compared every cycle, plus hand-computed expectations per scenario.
module tb_regfile_wb_arbiter;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic        clk;
  logic        reset;
  logic        pipe_wr_enable;
  logic [4:0]  pipe_W_addr;
  logic [31:0] pipe_W_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  W_addr;
  logic [31:0] W_data;
  logic        wr_enable;
  logic [31:0] pending_mask;
  logic        stall_req;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  regfile_wb_arbiter #(
    .width        (WIDTH),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_wr_enable (pipe_wr_enable),
    .pipe_W_addr    (pipe_W_addr),
    .pipe_W_data    (pipe_W_data),
    .lu_valid       (lu_valid),
    .lu_addr        (lu_addr),
    .lu_data        (lu_data),
    .lu_ready       (lu_ready),
    .W_addr         (W_addr),
    .W_data         (W_data),
    .wr_enable      (wr_enable),
    .pending_mask   (pending_mask),
    .stall_req      (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted LU results plus the visible port state.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_from_lu;
  int          m_blocked;
  logic        m_stall;
  logic [31:0] m_mask;

  always @(posedge clk) begin
    bit   had_entries, can_accept, pipe_real;
    ent_t e;
    if (reset) begin
      mq.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_from_lu = 0;
      m_blocked = 0; m_stall = 0;
    end else begin
      had_entries = (mq.size() > 0);
      can_accept  = (mq.size() < DEPTH);
      pipe_real   = pipe_wr_enable && (pipe_W_addr != 0);
      if (pipe_real) begin
        m_we = 1; m_addr = pipe_W_addr; m_data = pipe_W_data; m_from_lu = 0;
        m_blocked = had_entries ? ((m_blocked < STARVE) ? m_blocked + 1 : STARVE) : 0;
      end else if (had_entries) begin
        e = mq.pop_front();
        m_we = 1; m_addr = e.a; m_data = e.d; m_from_lu = 1;
        m_blocked = 0;
      end else begin
        m_we = 0;
        m_blocked = 0;
      end
      m_stall = (m_blocked == STARVE);
      if (lu_valid && can_accept && lu_addr != 0) begin
        e.a = lu_addr; e.d = lu_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_mask = 32'h0;
      foreach (mq[i]) m_mask[mq[i].a] = 1'b1;
      if (m_we && m_from_lu) m_mask[m_addr] = 1'b1;
      check("cmp_wr_enable", 64'(wr_enable), 64'(m_we));
      check("cmp_W_addr", 64'(W_addr), 64'(m_addr));
      check("cmp_W_data", 64'(W_data), 64'(m_data));
      check("cmp_lu_ready", 64'(lu_ready), 64'(mq.size() < DEPTH));
      check("cmp_pending_mask", 64'(pending_mask), 64'(m_mask));
      check("cmp_stall_req", 64'(stall_req), 64'(m_stall));
    end
  end

  task automatic set_in(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_wr_enable = pwe; pipe_W_addr = pa; pipe_W_data = pd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    next(); next();
    check("rst_wr_enable", 64'(wr_enable), 64'd0);
    check("rst_W_addr", 64'(W_addr), 64'd0);
    check("rst_W_data", 64'(W_data), 64'd0);
    check("rst_stall_req", 64'(stall_req), 64'd0);
    check("rst_lu_ready", 64'(lu_ready), 64'd1);
    check("rst_pending_mask", 64'(pending_mask), 64'd0);
    chk_en = 1;
    reset  = 1'b0;
    next();

    // Pipeline only, then a discarded write to r0 leaves the port holding.
    set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    next();
    check("pipe_we", 64'(wr_enable), 64'd1);
    check("pipe_addr", 64'(W_addr), 64'd5);
    check("pipe_data", 64'(W_data), 64'hDEADBEEF);
    set_in(1, 5'd0, 32'h1234, 0, 0, 0);
    next();
    check("pipe_r0_we", 64'(wr_enable), 64'd0);
    check("pipe_r0_hold_addr", 64'(W_addr), 64'd5);
    check("pipe_r0_hold_data", 64'(W_data), 64'hDEADBEEF);

    // LU only: two-cycle latency, mask covers queue and output stage.
    set_in(0, 0, 0, 1, 5'd7, 32'h11);
    next();
    set_in(0, 0, 0, 0, 0, 0);
    check("lu_mask_queued", 64'(pending_mask[7]), 64'd1);
    check("lu_not_yet", 64'(wr_enable), 64'd0);
    next();
    check("lu_we", 64'(wr_enable), 64'd1);
    check("lu_addr", 64'(W_addr), 64'd7);
    check("lu_data", 64'(W_data), 64'h11);
    check("lu_mask_out", 64'(pending_mask[7]), 64'd1);
    next();
    check("lu_mask_clear", 64'(pending_mask), 64'd0);

    // LU handshake to r0 completes but stores nothing.
    set_in(0, 0, 0, 1, 5'd0, 32'h99);
    next();
    set_in(0, 0, 0, 0, 0, 0);
    check("lu_r0_mask", 64'(pending_mask), 64'd0);
    next();
    check("lu_r0_we", 64'(wr_enable), 64'd0);

    // Fill while the pipeline owns the port, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 5'(20 + i), 32'(32'hA000 + i), 1, 5'(i), 32'(32'h100 + i));
      next();
    end
    check("full_ready", 64'(lu_ready), 64'd0);
    check("full_mask", 64'(pending_mask), 64'h1E);
    set_in(1, 5'd21, 32'hA005, 1, 5'd30, 32'hBAD);
    next();
    check("full_reject_ready", 64'(lu_ready), 64'd0);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      next();
      check("drain_we", 64'(wr_enable), 64'd1);
      check("drain_addr", 64'(W_addr), 64'(i));
      check("drain_data", 64'(W_data), 64'(32'h100 + i));
      if (i == 1) check("drain_ready_back", 64'(lu_ready), 64'd1);
    end
    next();
    check("drain_done_we", 64'(wr_enable), 64'd0);
    check("drain_done_mask", 64'(pending_mask), 64'd0);

    // Starvation: one queued entry blocked by continuous pipeline writes.
    set_in(1, 5'd3, 32'h0, 1, 5'd12, 32'hCAFE);
    next();
    for (int k = 1; k <= 10; k++) begin
      set_in(1, 5'd3, 32'(k), 0, 0, 0);
      next();
      check("starve_stall", 64'(stall_req), 64'(k >= STARVE));
    end
    set_in(0, 0, 0, 0, 0, 0);
    next();
    check("starve_lu_we", 64'(wr_enable), 64'd1);
    check("starve_lu_addr", 64'(W_addr), 64'd12);
    check("starve_lu_data", 64'(W_data), 64'hCAFE);
    check("starve_drop", 64'(stall_req), 64'd0);
    next();

    // Same-register duplicates keep the bit until the last one leaves.
    set_in(1, 5'd4, 32'h44, 1, 5'd9, 32'h901);
    next();
    set_in(1, 5'd4, 32'h45, 1, 5'd9, 32'h902);
    next();
    set_in(0, 0, 0, 0, 0, 0);
    check("dup_mask_q2", 64'(pending_mask), 64'h200);
    next();
    check("dup_first", 64'(W_data), 64'h901);
    check("dup_mask_1", 64'(pending_mask[9]), 64'd1);
    next();
    check("dup_second", 64'(W_data), 64'h902);
    check("dup_mask_2", 64'(pending_mask[9]), 64'd1);
    next();
    check("dup_mask_clear", 64'(pending_mask[9]), 64'd0);

    // Push and pop in the same cycle keeps occupancy unchanged.
    set_in(0, 0, 0, 1, 5'd15, 32'h150);
    next();
    set_in(0, 0, 0, 1, 5'd16, 32'h160);
    next();
    set_in(0, 0, 0, 0, 0, 0);
    check("pushpop_addr", 64'(W_addr), 64'd15);
    check("pushpop_mask", 64'(pending_mask), 64'h18000);
    next(); next();

    // Reset mid-drain flushes everything queued.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'd2, 32'(i), 1, 5'(10 + i), 32'(32'hA0 + i));
      next();
    end
    set_in(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    next();
    reset = 1'b0;
    check("rstmid_we", 64'(wr_enable), 64'd0);
    check("rstmid_mask", 64'(pending_mask), 64'd0);
    check("rstmid_ready", 64'(lu_ready), 64'd1);
    check("rstmid_addr", 64'(W_addr), 64'd0);
    for (int i = 0; i < 4; i++) begin
      next();
      check("rstmid_no_write", 64'(wr_enable), 64'd0);
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
